// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register and the
// inter-stage bundle layouts that travel through it.
package pipe_pkg;

  // Stage occupancy: EMPTY, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  localparam int unsigned DEF_DATA_W = 70;
  localparam int unsigned DEF_CNT_W  = 16;

  // IF->ID bundle: {pc[31:0], instr[31:0]}
  localparam int unsigned IFID_INSTR_LSB = 0;
  localparam int unsigned IFID_PC_LSB    = 32;
  localparam int unsigned IFID_W         = 64;

  // MEM->WB bundle: {wb_en, mem_read, dest[3:0], alu_result[31:0], mem_data[31:0]}
  localparam int unsigned MEMWB_MEM_LSB      = 0;
  localparam int unsigned MEMWB_MEM_W        = 32;
  localparam int unsigned MEMWB_ALU_LSB      = 32;
  localparam int unsigned MEMWB_ALU_W        = 32;
  localparam int unsigned MEMWB_DEST_LSB     = 64;
  localparam int unsigned MEMWB_DEST_W       = 4;
  localparam int unsigned MEMWB_MEM_READ_BIT = 68;
  localparam int unsigned MEMWB_WB_EN_BIT    = 69;
  localparam int unsigned MEMWB_W            = 70;

  function automatic logic [MEMWB_W-1:0] memwb_pack(
    input logic        wb_en,
    input logic        mem_read,
    input logic [3:0]  dest,
    input logic [31:0] alu_result,
    input logic [31:0] mem_data
  );
    memwb_pack = {wb_en, mem_read, dest, alu_result, mem_data};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear on request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer so that
// in_ready is a flop, plus synchronous flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  occ_t              state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  logic [DATA_W-1:0] skid_q, skid_nx;
  logic              in_fire, out_fire;

  assign out_data = main_q;

  // Occupancy, data registers and the registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      out_valid <= (state_nx != ST_EMPTY);
      in_ready  <= (state_nx != ST_FULL);
    end
  end

  // Next occupancy and data moves; flush overrides every handshake.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nx = '0;
        skid_nx = '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_nx  = in_data;
            state_nx = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_nx = in_data;
          end else if (in_fire) begin
            skid_nx  = in_data;
            state_nx = ST_FULL;
          end else if (out_fire) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_nx  = skid_q;
            state_nx = ST_ONE;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid & ~out_ready & ~flush),
    .clr(stall_clr),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the stage.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = 70;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready_s, out_valid_s;
  logic [DW-1:0] out_data_s;
  logic [3:0]    stall_cnt_s;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: FIFO of held entries (capacity 2) and stall counts.
  logic [DW-1:0] mq[$];
  int unsigned   m_st16 = 0;
  int unsigned   m_st4  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_skid #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s), .stall_clr(stall_clr)
  );

  // Advance one clock: update the model from the inputs seen at the edge,
  // then return at the following falling edge for sampling.
  task automatic step();
    bit v, inf, outf;
    @(posedge clk);
    v    = (mq.size() > 0);
    inf  = in_valid && (mq.size() < 2);
    outf = v && out_ready;
    if (stall_clr) begin
      m_st16 = 0;
      m_st4  = 0;
    end else if (v && !out_ready && !flush) begin
      if (m_st16 < 65535) m_st16++;
      if (m_st4 < 15) m_st4++;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic go_empty();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    rst = 1'b0;
    mq.delete(); m_st16 = 0; m_st4 = 0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, DW'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall[%0d] got=%0d exp=0", i, stall_cnt); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    go_empty();
    out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(32'hA);
    step();
    out_ready = 1'b0; in_data = DW'(32'hB);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_hold_a got=%h exp=a", out_data); end
    in_valid = 1'b0;
    step();
    checks++; if (out_data !== DW'(32'hA) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got=%h/%b exp=a/1", out_data, out_valid); end
    checks++; if (stall_cnt !== 16'(m_st16)) begin errors++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, m_st16); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== DW'(32'hB) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_b_next got=%h/%b exp=b/1", out_data, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    go_empty();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'hC);
    step();
    in_data = DW'(32'hD);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
    flush = 1'b1; in_data = DW'(32'hE);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_data got=%h exp=0", out_data); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_e got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall_sat();
    go_empty();
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin errors++; $display("FAIL sat_pre_clr got=%0d/%0d exp=0/0", stall_cnt, stall_cnt_s); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h55);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_w4 got=%0d exp=15", stall_cnt_s); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_w16 got=%0d exp=20", stall_cnt); end
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin errors++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", stall_cnt, stall_cnt_s); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_legacy();
    logic [DW-1:0] b;
    go_empty();
    out_ready = 1'b1;
    b = memwb_pack(1'b1, 1'b1, 4'h7, 32'h10, 32'hDEADBEEF);
    in_valid = 1'b1; in_data = b;
    step();
    checks++; if (out_data !== b) begin errors++; $display("FAIL legacy_bundle got=%h exp=%h", out_data, b); end
    checks++; if (out_data[MEMWB_DEST_LSB +: 4] !== 4'h7 || out_data[MEMWB_WB_EN_BIT] !== 1'b1) begin errors++; $display("FAIL legacy_fields got=%h exp=7/1", out_data[MEMWB_DEST_LSB +: 4]); end
    for (int i = 0; i < 6; i++) begin
      b = memwb_pack(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
      in_data = b;
      step();
      checks++; if (out_data !== b || in_ready !== 1'b1) begin errors++; $display("FAIL legacy_seq[%0d] got=%h/%b exp=%h/1", i, out_data, in_ready, b); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [95:0] r;
    bit hold;
    go_empty();
    for (int i = 0; i < 400; i++) begin
      hold = in_valid && (mq.size() >= 2);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r = {$urandom, $urandom, $urandom};
        in_data = r[DW-1:0];
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      step();
      checks++; if (out_valid !== (mq.size() > 0) || out_valid_s !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b/%b exp=%b", i, out_valid, out_valid_s, mq.size() > 0); end
      checks++; if (in_ready !== (mq.size() < 2) || in_ready_s !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%b/%b exp=%b", i, in_ready, in_ready_s, mq.size() < 2); end
      if (mq.size() > 0) begin
        checks++; if (out_data !== mq[0] || out_data_s !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, out_data, mq[0]); end
      end
      checks++; if (stall_cnt !== 16'(m_st16) || stall_cnt_s !== 4'(m_st4)) begin errors++; $display("FAIL rnd_stall[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, stall_cnt_s, m_st16, m_st4); end
    end
    flush = 1'b0; stall_clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    go_empty();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h11);
    step();
    in_data = DW'(32'h22);
    step();
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || stall_cnt === 16'd0) begin errors++; $display("FAIL areset_pre got=%b/%0d exp=0/nonzero", in_ready, stall_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_valid_s !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin errors++; $display("FAIL areset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL areset_data got=%h exp=0", out_data); end
    mq.delete(); m_st16 = 0; m_st4 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_stall_sat();
    test_legacy();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque DATA_W-bit bundle using a valid/ready handshake, with synchronous flush (branch/exception squash).
- A 2-entry skid buffer registers in_ready, so back-pressure never forms a combinational path through the stage.
- A saturating stall counter gives per-stage performance visibility.

Parameters:
- DATA_W, 70, bundle width (wb_en, mem_read, dest[3:0], alu_result[31:0], mem_data[31:0] for the MEM->WB instance).
- CLEAR_ON_FLUSH, 1, when 1 a flush also zeroes the data registers; when 0 only the valid bits are cleared.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_W  upstream bundle.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  bundle to next stage; driven from main register.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset values: out_valid=0, out_data=0, skid valid=0, skid data=0, in_ready=1, stall_cnt=0. State after reset is EMPTY.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_data is sampled only on in_fire. Upstream holds in_data while in_valid=1 and in_ready=0.
- State: 2-bit occupancy, one of EMPTY (0), ONE (main only), FULL (main + skid). in_ready = (state != FULL), registered.
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data; go to ONE. Latency is 1 cycle from in_fire to out_valid.
  - ONE, in_fire & out_fire: main<=in_data; stay in ONE. Sustains 1 transfer/cycle.
  - ONE, in_fire & !out_fire: skid<=in_data; go to FULL. in_ready=0 next cycle.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main<=skid; go to ONE. No input is accepted that cycle because in_ready=0.
  - FULL, !out_fire: hold.
  - Any other combination: hold.
- Ordering: strict FIFO. No entry is lost or duplicated, and out_data is stable while out_valid=1 and out_ready=0.
- Flush (flush=1):
  - Next state is EMPTY; in_ready=1 next cycle.
  - Flush has priority over simultaneous in_fire (the input is dropped) and over out_fire. Downstream may still sample the out_fire transfer that cycle; the stage state is then EMPTY.
  - Data registers are zeroed only if CLEAR_ON_FLUSH=1.
- Stall counter:
  - Increments when out_valid & !out_ready & !flush, and saturates at all-ones (no wrap).
  - stall_clr zeroes it and has priority over increment.
  - Not affected by flush.
- Reset mid-operation: all entries are discarded immediately (async) and the reset values apply.
- Legacy mode: out_ready tied to 1 behaves as a plain 1-cycle register with valid = wb-style enable. The stage never enters FULL.

Decomposition:
- Shared package pipe_pkg holds:
  - the occupancy enum (ST_EMPTY, ST_ONE, ST_FULL);
  - default width constants;
  - field offset localparams for each inter-stage bundle (e.g. MEMWB_DEST_LSB).
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; output cnt), used for stall_cnt.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while FULL -> out_valid=0, in_ready=1, stall_cnt=0 immediately, with no clock edge required.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> each value appears on out_data exactly 1 cycle later; in_ready stays 1; stall_cnt=0.
- Back-pressure: in state ONE holding 0xA, drop out_ready and push 0xB -> FULL, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA, then 0xB delivered in order, and in_ready returns to 1 after 0xA drains.
- Flush priority: FULL with 0xC/0xD, assert flush with in_valid=1 (0xE) -> next cycle EMPTY, out_valid=0, 0xE never appears, out_data=0 (CLEAR_ON_FLUSH=1).
- Stall saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays there. Pulse stall_clr -> 0.
- Legacy MEM->WB: out_ready tied 1, drive the 70-bit bundle {wb_en=1, mem_read=1, dest=4'h7, alu=32'h10, mem=32'hDEADBEEF} -> the identical bundle appears 1 cycle later.
